uart_rx_fifo: RTL and testbench

Receive-side buffer for the 6502 test system's UART. It sits directly downstream of the UART receiver and absorbs each received byte strobe into a FIFO, so the CPU no longer has to poll within one character time. It presents the buffered bytes, a fill count and overrun/status flags on the same 8-bit chip-select bus as the other memory-mapped peripherals. It can optionally raise a CPU interrupt.

---
 rtl/uart_pkg.sv | 24 ++
 rtl/sync_fifo.sv | 81 ++++++++
 rtl/uart_rx_fifo.sv | 152 +++++++++++++++
 tb/tb_uart_rx_fifo.sv | 184 ++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions: register map of the receive FIFO, its status and
// control bit positions, and the receiver baud-delay constants.
package uart_pkg;

  localparam logic [1:0] UART_FIFO_STATUS = 2'd0;
  localparam logic [1:0] UART_FIFO_DATA   = 2'd1;
  localparam logic [1:0] UART_FIFO_COUNT  = 2'd2;
  localparam logic [1:0] UART_FIFO_CTRL   = 2'd3;

  localparam int STAT_NOT_EMPTY_BIT   = 32'sd0;
  localparam int STAT_IRQ_PENDING_BIT = 32'sd1;
  localparam int STAT_FULL_BIT        = 32'sd6;
  localparam int STAT_OVERRUN_BIT     = 32'sd7;

  localparam int CTRL_FLUSH_BIT   = 32'sd0;
  localparam int CTRL_IRQ_EN_BIT  = 32'sd1;
  localparam int CTRL_CLR_OVR_BIT = 32'sd2;

  localparam int UART_CLK_HZ        = 32'sd27_000_000;
  localparam int UART_BAUD          = 32'sd115_200;
  localparam int UART_BAUD_DIV      = UART_CLK_HZ / UART_BAUD;
  localparam int UART_HALF_BAUD_DIV = UART_BAUD_DIV / 32'sd2;

endpackage

// File: rtl/sync_fifo.sv
// Byte FIFO with flush; flush overrides push/pop, and a push into a full
// FIFO is accepted only when a pop frees the head in the same cycle.
module sync_fifo #(
  parameter int DEPTH_LOG2 = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  push,
  input  logic                  pop,
  input  logic                  flush,
  input  logic [7:0]            wdata,
  output logic [7:0]            rdata,
  output logic [DEPTH_LOG2:0]   count,
  output logic                  full,
  output logic                  empty
);

  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0]   CNT_FULL = {1'b1, {DEPTH_LOG2{1'b0}}};
  localparam logic [DEPTH_LOG2:0]   CNT_ONE  = {{DEPTH_LOG2{1'b0}}, 1'b1};
  localparam logic [DEPTH_LOG2-1:0] PTR_ONE  = {{(DEPTH_LOG2-1){1'b0}}, 1'b1};

  logic [7:0]            mem_q [DEPTH];
  logic [DEPTH_LOG2-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
  logic [DEPTH_LOG2:0]   count_q, count_d;
  logic                  do_push_s, do_pop_s;

  assign full      = (count_q == CNT_FULL);
  assign empty     = (count_q == {(DEPTH_LOG2+1){1'b0}});
  assign count     = count_q;
  assign rdata     = mem_q[rptr_q];
  assign do_pop_s  = pop && !empty;
  assign do_push_s = push && (!full || do_pop_s);

  always_comb begin
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    count_d = count_q;
    if (flush) begin
      wptr_d  = {DEPTH_LOG2{1'b0}};
      rptr_d  = {DEPTH_LOG2{1'b0}};
      count_d = {(DEPTH_LOG2+1){1'b0}};
    end else begin
      if (do_push_s) begin
        wptr_d = wptr_q + PTR_ONE;
      end else begin
        wptr_d = wptr_q;
      end
      if (do_pop_s) begin
        rptr_d = rptr_q + PTR_ONE;
      end else begin
        rptr_d = rptr_q;
      end
      case ({do_push_s, do_pop_s})
        2'b10:   count_d = count_q + CNT_ONE;
        2'b01:   count_d = count_q - CNT_ONE;
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wptr_q  <= {DEPTH_LOG2{1'b0}};
      rptr_q  <= {DEPTH_LOG2{1'b0}};
      count_q <= {(DEPTH_LOG2+1){1'b0}};
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      count_q <= count_d;
    end
  end

  // Storage is not reset; the pointers alone define what is valid.
  always_ff @(posedge clk) begin
    if (do_push_s && !flush) begin
      mem_q[wptr_q] <= wdata;
    end
  end

endmodule

// File: rtl/uart_rx_fifo.sv
// UART receive FIFO on the CPU chip-select bus with status/count/control
// registers. Define UART_RX_FIFO_IRQ_EN to build the optional interrupt path.
module uart_rx_fifo
  import uart_pkg::*;
#(
  parameter int DEPTH_LOG2 = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] AB,
  input  logic [7:0] DI,
  output logic [7:0] DO,
  input  logic       CS,
  input  logic       WE,
  input  logic [7:0] rx_data,
  input  logic       rx_valid,
  output logic       irq_n
);

  logic                rd_acc_s, rd_data_acc_s, ctrl_wr_acc_s;
  logic                rd_data_acc_q, ctrl_wr_acc_q;
  logic                pop_new_s, ctrl_new_s, flush_s, clr_ovr_s;
  logic                pop_eff_s, overflow_s;
  logic [7:0]          head_s;
  logic [DEPTH_LOG2:0] count_s;
  logic                full_s, empty_s, not_empty_s;
  logic                overrun_q, overrun_d;
  logic                irq_en_s, irq_pending_s;
  logic [7:0]          status_s, count_rd_s, ctrl_rd_s;
  logic [7:0]          rdata_q, rdata_d;
  logic                oe_q;
  logic                unused_s;

  assign unused_s = ^{AB[7:2], DI[7:3], DI[1]};

  assign rd_acc_s      = CS && !WE;
  assign rd_data_acc_s = CS && (AB[1:0] == UART_FIFO_DATA) && !WE;
  assign ctrl_wr_acc_s = CS && (AB[1:0] == UART_FIFO_CTRL) && WE;
  assign pop_new_s     = rd_data_acc_s && !rd_data_acc_q;
  assign ctrl_new_s    = ctrl_wr_acc_s && !ctrl_wr_acc_q;
  assign flush_s       = ctrl_new_s && DI[CTRL_FLUSH_BIT];
  assign clr_ovr_s     = ctrl_new_s && DI[CTRL_CLR_OVR_BIT];
  assign not_empty_s   = !empty_s;
  assign pop_eff_s     = pop_new_s && not_empty_s;
  assign overflow_s    = rx_valid && full_s && !pop_eff_s && !flush_s;

  sync_fifo #(.DEPTH_LOG2(DEPTH_LOG2)) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (rx_valid),
    .pop   (pop_new_s),
    .flush (flush_s),
    .wdata (rx_data),
    .rdata (head_s),
    .count (count_s),
    .full  (full_s),
    .empty (empty_s)
  );

  // A fresh overflow beats a simultaneous clear.
  always_comb begin
    overrun_d = overrun_q;
    if (overflow_s) begin
      overrun_d = 1'b1;
    end else if (clr_ovr_s) begin
      overrun_d = 1'b0;
    end else begin
      overrun_d = overrun_q;
    end
  end

`ifdef UART_RX_FIFO_IRQ_EN
  logic irq_en_q, irq_en_d, irq_n_q;

  always_comb begin
    irq_en_d = irq_en_q;
    if (ctrl_new_s) begin
      irq_en_d = DI[CTRL_IRQ_EN_BIT];
    end else begin
      irq_en_d = irq_en_q;
    end
  end

  assign irq_en_s      = irq_en_q;
  assign irq_pending_s = irq_en_q && (not_empty_s || overrun_q);
  assign irq_n         = irq_n_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      irq_en_q <= 1'b0;
      irq_n_q  <= 1'b1;
    end else begin
      irq_en_q <= irq_en_d;
      irq_n_q  <= !irq_pending_s;
    end
  end
`else
  assign irq_en_s      = 1'b0;
  assign irq_pending_s = 1'b0;
  assign irq_n         = 1'b1;
`endif

  // Read mux sees pre-update state; held data reads repeat the popped byte.
  always_comb begin
    status_s                       = 8'h00;
    status_s[STAT_OVERRUN_BIT]     = overrun_q;
    status_s[STAT_FULL_BIT]        = full_s;
    status_s[STAT_IRQ_PENDING_BIT] = irq_pending_s;
    status_s[STAT_NOT_EMPTY_BIT]   = not_empty_s;
    count_rd_s                     = 8'h00;
    count_rd_s[DEPTH_LOG2:0]       = count_s;
    ctrl_rd_s                      = 8'h00;
    ctrl_rd_s[CTRL_IRQ_EN_BIT]     = irq_en_s;
    rdata_d                        = rdata_q;
    if (rd_acc_s) begin
      case (AB[1:0])
        UART_FIFO_STATUS: rdata_d = status_s;
        UART_FIFO_DATA: begin
          if (pop_new_s) begin
            rdata_d = not_empty_s ? head_s : 8'h00;
          end else begin
            rdata_d = rdata_q;
          end
        end
        UART_FIFO_COUNT:  rdata_d = count_rd_s;
        UART_FIFO_CTRL:   rdata_d = ctrl_rd_s;
        default:          rdata_d = rdata_q;
      endcase
    end else begin
      rdata_d = rdata_q;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rd_data_acc_q <= 1'b0;
      ctrl_wr_acc_q <= 1'b0;
      overrun_q     <= 1'b0;
      rdata_q       <= 8'h00;
      oe_q          <= 1'b0;
    end else begin
      rd_data_acc_q <= rd_data_acc_s;
      ctrl_wr_acc_q <= ctrl_wr_acc_s;
      overrun_q     <= overrun_d;
      rdata_q       <= rdata_d;
      oe_q          <= rd_acc_s;
    end
  end

  assign DO = oe_q ? rdata_q : 8'hzz;

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Directed, table-driven bench for uart_rx_fifo; DO is pulled up so an
// undriven bus reads as 8'hFF.
module tb_uart_rx_fifo;

  localparam int K_PUSH = 0;
  localparam int K_RD   = 1;
  localparam int K_WR   = 2;
  localparam logic [7:0] HIZ = 8'hFF;
`ifdef UART_RX_FIFO_IRQ_EN
  localparam logic [7:0] IRQ_ST  = 8'h02;
  localparam logic       IRQ_LOW = 1'b0;
`else
  localparam logic [7:0] IRQ_ST  = 8'h00;
  localparam logic       IRQ_LOW = 1'b1;
`endif

  typedef struct {
    int         kind;
    logic [1:0] addr;
    logic [7:0] data;
    logic [7:0] exp;
    string      name;
  } vec_t;

  logic       clk = 1'b0;
  logic       rst_n, cs, we, rx_valid;
  logic [7:0] ab, di, rx_data;
  wire  [7:0] do_w;
  logic       irq_n;
  int         n_pass = 0;
  int         n_total = 0;
  vec_t       vecs[$];

  for (genvar gi = 0; gi < 8; gi++) begin : g_pu
    pullup (do_w[gi]);
  end

  always #5 clk = ~clk;

  uart_rx_fifo #(.DEPTH_LOG2(4)) dut (
    .clk(clk), .reset(rst_n), .AB(ab), .DI(di), .DO(do_w), .CS(cs),
    .WE(we), .rx_data(rx_data), .rx_valid(rx_valid), .irq_n(irq_n)
  );

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %02h expected %02h", name, act, exp);
  endtask

  task automatic push(input logic [7:0] d);
    @(negedge clk); rx_valid = 1'b1; rx_data = d;
    @(negedge clk); rx_valid = 1'b0;
  endtask

  task automatic rd(input logic [1:0] a, output logic [7:0] v);
    @(negedge clk); cs = 1'b1; we = 1'b0; ab = {6'd0, a};
    @(negedge clk); cs = 1'b0; v = do_w;
  endtask

  task automatic wr(input logic [1:0] a, input logic [7:0] d);
    @(negedge clk); cs = 1'b1; we = 1'b1; ab = {6'd0, a}; di = d;
    @(negedge clk); cs = 1'b0; we = 1'b0;
  endtask

  function automatic void add(input int k, input logic [1:0] a, input logic [7:0] d,
                              input logic [7:0] e, input string n);
    vec_t v;
    v.kind = k; v.addr = a; v.data = d; v.exp = e; v.name = n;
    vecs.push_back(v);
  endfunction

  initial begin
    logic [7:0] v;
    // Basic order and reset register values.
    add(K_RD, 2'd0, 8'h00, 8'h00, "reset_status");
    add(K_RD, 2'd2, 8'h00, 8'h00, "reset_count");
    add(K_RD, 2'd3, 8'h00, 8'h00, "reset_ctrl");
    add(K_PUSH, 2'd0, 8'h41, 8'h00, "");
    add(K_PUSH, 2'd0, 8'h42, 8'h00, "");
    add(K_PUSH, 2'd0, 8'h43, 8'h00, "");
    add(K_RD, 2'd2, 8'h00, 8'h03, "count3");
    add(K_RD, 2'd0, 8'h00, 8'h01, "status_ne");
    add(K_RD, 2'd1, 8'h00, 8'h41, "pop41");
    add(K_RD, 2'd1, 8'h00, 8'h42, "pop42");
    add(K_RD, 2'd1, 8'h00, 8'h43, "pop43");
    add(K_RD, 2'd0, 8'h00, 8'h00, "status_empty");
    add(K_RD, 2'd1, 8'h00, 8'h00, "pop_empty");
    add(K_RD, 2'd2, 8'h00, 8'h00, "count_empty");
    // Overflow by one, drain, clear overrun.
    for (int i = 0; i < 17; i++) add(K_PUSH, 2'd0, 8'(i), 8'h00, "");
    add(K_RD, 2'd0, 8'h00, 8'hC1, "status_ovr_full");
    add(K_RD, 2'd2, 8'h00, 8'h10, "count16");
    for (int i = 0; i < 16; i++) add(K_RD, 2'd1, 8'h00, 8'(i), "pop_full_order");
    add(K_RD, 2'd0, 8'h00, 8'h80, "status_ovr_sticky");
    add(K_WR, 2'd3, 8'h04, 8'h00, "");
    add(K_RD, 2'd0, 8'h00, 8'h00, "status_ovr_clr");
    // Flush and ignored writes.
    for (int i = 0; i < 5; i++) add(K_PUSH, 2'd0, 8'hA0 + 8'(i), 8'h00, "");
    add(K_RD, 2'd2, 8'h00, 8'h05, "count5");
    add(K_WR, 2'd0, 8'h01, 8'h00, "");
    add(K_RD, 2'd2, 8'h00, 8'h05, "wr_addr0_ignored");
    add(K_WR, 2'd3, 8'h01, 8'h00, "");
    add(K_RD, 2'd2, 8'h00, 8'h00, "count_flushed");
    add(K_RD, 2'd1, 8'h00, 8'h00, "pop_after_flush");
    // Interrupt enable visible in ctrl/status.
    add(K_WR, 2'd3, 8'h02, 8'h00, "");
    add(K_RD, 2'd3, 8'h00, IRQ_ST, "ctrl_irq_en");
    add(K_RD, 2'd0, 8'h00, 8'h00, "status_irq_idle");
    add(K_PUSH, 2'd0, 8'h77, 8'h00, "");
    add(K_RD, 2'd0, 8'h00, 8'h01 | IRQ_ST, "status_irq_pend");
    add(K_RD, 2'd1, 8'h00, 8'h77, "pop77");
    add(K_WR, 2'd3, 8'h00, 8'h00, "");
    add(K_RD, 2'd3, 8'h00, 8'h00, "ctrl_cleared");

    rst_n = 1'b0; cs = 1'b0; we = 1'b0; ab = 8'h00; di = 8'h00;
    rx_valid = 1'b0; rx_data = 8'h00;
    repeat (2) @(negedge clk);
    check("reset_do_hiz", do_w, HIZ);
    check("reset_irq_n", {7'd0, irq_n}, 8'h01);
    rst_n = 1'b1;

    foreach (vecs[i]) begin
      case (vecs[i].kind)
        K_PUSH:  push(vecs[i].data);
        K_WR:    wr(vecs[i].addr, vecs[i].data);
        default: begin
          rd(vecs[i].addr, v);
          check(vecs[i].name, v, vecs[i].exp);
        end
      endcase
    end

    // Held data read pops once; DO tri-states one cycle after CS drops.
    push(8'hAA); push(8'hBB);
    @(negedge clk); cs = 1'b1; we = 1'b0; ab = 8'h01;
    @(negedge clk); check("held_first", do_w, 8'hAA);
    repeat (3) @(negedge clk);
    check("held_last", do_w, 8'hAA);
    cs = 1'b0;
    check("held_drop_driven", do_w, 8'hAA);
    @(negedge clk); check("held_hiz", do_w, HIZ);
    rd(2'd2, v); check("held_count1", v, 8'h01);
    rd(2'd1, v); check("held_popBB", v, 8'hBB);

    // Full FIFO: pop and push in the same cycle.
    for (int i = 0; i < 16; i++) push(8'h20 + 8'(i));
    @(negedge clk); cs = 1'b1; we = 1'b0; ab = 8'h01; rx_valid = 1'b1; rx_data = 8'h99;
    @(negedge clk); cs = 1'b0; rx_valid = 1'b0;
    check("fullpp_head", do_w, 8'h20);
    rd(2'd2, v); check("fullpp_count", v, 8'h10);
    rd(2'd0, v); check("fullpp_status", v, 8'h41);
    for (int i = 1; i < 16; i++) begin
      rd(2'd1, v); check("fullpp_order", v, 8'h20 + 8'(i));
    end
    rd(2'd1, v); check("fullpp_last", v, 8'h99);

    // Interrupt timing relative to push and pop.
    wr(2'd3, 8'h02);
    @(negedge clk); rx_valid = 1'b1; rx_data = 8'h55;
    @(negedge clk); rx_valid = 1'b0;
    check("irq_one_edge", {7'd0, irq_n}, 8'h01);
    @(negedge clk); check("irq_two_edges", {7'd0, irq_n}, {7'd0, IRQ_LOW});
    rd(2'd1, v); check("irq_pop55", v, 8'h55);
    check("irq_pop_edge", {7'd0, irq_n}, {7'd0, IRQ_LOW});
    @(negedge clk); check("irq_released", {7'd0, irq_n}, 8'h01);
    wr(2'd3, 8'h00);

    // Reset in the middle of a read.
    push(8'h66);
    @(negedge clk); cs = 1'b1; we = 1'b0; ab = 8'h01;
    @(negedge clk); check("rst_mid_driven", do_w, 8'h66);
    #2 rst_n = 1'b0;
    #1 check("rst_mid_hiz", do_w, HIZ);
    cs = 1'b0;
    @(negedge clk); rst_n = 1'b1;
    rd(2'd2, v); check("rst_count", v, 8'h00);
    rd(2'd0, v); check("rst_status", v, 8'h00);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
